job_latency_stub: RTL and testbench

Parametrised stand-in for a long-running compute job in the nonogram generator pipeline. It accepts a start request, stays busy for a programmable number of clock cycles, then reports completion with a fixed result pixel. It replaces hard-coded fixed-delay placeholders, so the surrounding FSMs and display path can be exercised before the real generator exists. It adds per-job delay, abort, back-to-back restart and a completion counter.

---
 rtl/job_latency_stub.sv | 126 ++++++++++++
 tb/tb_job_latency_stub.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/job_latency_stub.sv
// job_latency_stub: stand-in for a long-running generator job.
// Accepts a start, stays busy for a per-job number of cycles, then pulses
// done and presents a fixed result pixel. Supports abort, back-to-back
// restart from the done cycle and a wrapping completion counter.
// Optional feature: define JOB_STUB_REMAINING_EN to add remaining_out.
module job_latency_stub #(
    parameter int unsigned              CNT_WIDTH     = 32,
    parameter logic [CNT_WIDTH-1:0]     DEFAULT_DELAY = 50000,
    parameter int unsigned              PIXEL_WIDTH   = 12,
    parameter logic [PIXEL_WIDTH-1:0]   DONE_PIXEL    = 'h1FF
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic [CNT_WIDTH-1:0]   delay_in,
    input  logic                   abort_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   aborted_out,
    output logic                   on_out,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic [7:0]             done_count_out
`ifdef JOB_STUB_REMAINING_EN
    ,
    output logic [CNT_WIDTH-1:0]   remaining_out
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_len;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_aborted;
    logic                   r_on;
    logic [PIXEL_WIDTH-1:0] r_pixel;
    logic [7:0]             r_done_count;
    logic [CNT_WIDTH-1:0]   r_remaining;

    logic [CNT_WIDTH-1:0]   w_len_sel;
    logic                   w_last;

    // Job length chosen at start; zero request selects the default length.
    always_comb begin
        w_len_sel = (delay_in == '0) ? DEFAULT_DELAY : delay_in;
        w_last    = (r_cnt == (r_len - CNT_WIDTH'(1)));
    end

    // Job sequencer with all outputs registered; abort has priority over completion.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_on         <= 1'b0;
            r_pixel      <= '0;
            r_done_count <= '0;
            r_remaining  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_in) begin
                        r_len       <= w_len_sel;
                        r_cnt       <= '0;
                        r_pixel     <= '0;
                        r_busy      <= 1'b1;
                        r_remaining <= w_len_sel;
                        r_state     <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_in) begin
                        r_busy      <= 1'b0;
                        r_aborted   <= 1'b1;
                        r_cnt       <= '0;
                        r_remaining <= '0;
                        r_state     <= ST_IDLE;
                    end else if (w_last) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pixel      <= DONE_PIXEL;
                        r_on         <= 1'b1;
                        r_done_count <= r_done_count + 8'd1;
                        r_cnt        <= '0;
                        r_remaining  <= '0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt       <= r_cnt + CNT_WIDTH'(1);
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign aborted_out    = r_aborted;
    assign on_out         = r_on;
    assign pixel_out      = r_pixel;
    assign done_count_out = r_done_count;

`ifdef JOB_STUB_REMAINING_EN
    assign remaining_out = r_remaining;
`else
    logic w_unused;
    assign w_unused = ^r_remaining;
`endif

endmodule

// File: tb/tb_job_latency_stub.sv
// Testbench for job_latency_stub with DEFAULT_DELAY overridden to 20.
// A job-level model (cycles left in the current job) predicts every output
// each cycle; directed scenarios add hand-computed literal checks.
module tb_job_latency_stub;

    localparam int unsigned CW = 32;
    localparam int unsigned PW = 12;
    localparam logic [PW-1:0] DONE_PIX = 12'h1FF;
    localparam int unsigned DEF_LEN = 20;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          start_in = 1'b0;
    logic [CW-1:0] delay_in = '0;
    logic          abort_in = 1'b0;
    logic          busy_out, done_out, aborted_out, on_out;
    logic [PW-1:0] pixel_out;
    logic [7:0]    done_count_out;
`ifdef JOB_STUB_REMAINING_EN
    logic [CW-1:0] remaining_out;
`endif

    int vectors = 0;
    int miscompares = 0;

    job_latency_stub #(
        .CNT_WIDTH    (CW),
        .DEFAULT_DELAY(32'd20),
        .PIXEL_WIDTH  (PW),
        .DONE_PIXEL   (DONE_PIX)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .start_in      (start_in),
        .delay_in      (delay_in),
        .abort_in      (abort_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .aborted_out   (aborted_out),
        .on_out        (on_out),
        .pixel_out     (pixel_out),
        .done_count_out(done_count_out)
`ifdef JOB_STUB_REMAINING_EN
        ,
        .remaining_out (remaining_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: m_left = busy cycles still to go in the current job.
    int       m_left = 0;
    bit       e_busy = 0, e_done = 0, e_ab = 0, e_on = 0;
    int       e_pix = 0;
    int       e_cnt = 0;
    always @(posedge clk_in) begin
        if (reset_in) begin
            m_left = 0; e_busy = 0; e_done = 0; e_ab = 0; e_on = 0; e_pix = 0; e_cnt = 0;
        end else begin
            e_done = 0;
            e_ab   = 0;
            if (m_left > 0) begin
                if (abort_in) begin
                    m_left = 0; e_busy = 0; e_ab = 1;
                end else if (m_left == 1) begin
                    m_left = 0; e_busy = 0; e_done = 1; e_pix = DONE_PIX; e_on = 1;
                    e_cnt = (e_cnt + 1) % 256;
                end else begin
                    m_left = m_left - 1;
                end
            end else if (start_in) begin
                m_left = (delay_in == 0) ? DEF_LEN : int'(delay_in);
                e_busy = 1;
                e_pix  = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        chk("busy_out", busy_out, e_busy);
        chk("done_out", done_out, e_done);
        chk("aborted_out", aborted_out, e_ab);
        chk("on_out", on_out, e_on);
        chk("pixel_out", pixel_out, e_pix);
        chk("done_count_out", done_count_out, e_cnt);
`ifdef JOB_STUB_REMAINING_EN
        chk("remaining_out", remaining_out, m_left);
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Pulse start for one cycle; returns at the first busy cycle's negedge.
    task automatic start_job(input int d);
        @(negedge clk_in);
        start_in = 1'b1;
        delay_in = CW'(d);
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; stops in the cycle after busy drops.
    task automatic measure_busy(output int n);
        n = 0;
        while (busy_out && n < 200) begin
            n++;
            @(negedge clk_in);
        end
        if (n >= 200) chk("busy_timeout", n, 0);
    endtask

    initial begin
        int n, jobs, dones, busy_cyc, cyc;
        bit prev;

        repeat (3) @(negedge clk_in);
        chk("reset_busy", busy_out, 0);
        chk("reset_pixel", pixel_out, 0);
        chk("reset_count", done_count_out, 0);
        reset_in = 1'b0;

        // Basic job, len 5
        start_job(5);
        measure_busy(n);
        chk("len5_busy_cycles", n, 5);
        chk("len5_done", done_out, 1);
        chk("len5_pixel", pixel_out, 12'h1FF);
        chk("len5_on", on_out, 1);
        chk("len5_count", done_count_out, 1);
        @(negedge clk_in);
        chk("len5_done_single", done_out, 0);
        chk("len5_pixel_hold", pixel_out, 12'h1FF);

        // Zero delay selects default length 20
        start_job(0);
        chk("def_pixel_cleared", pixel_out, 0);
        measure_busy(n);
        chk("default_busy_cycles", n, 20);
        chk("default_count", done_count_out, 2);

        // Abort in busy cycle 4 of a 10-cycle job
        start_job(10);
        repeat (3) @(negedge clk_in);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("abort_pulse", aborted_out, 1);
        chk("abort_busy", busy_out, 0);
        chk("abort_no_done", done_out, 0);
        chk("abort_pixel", pixel_out, 0);
        chk("abort_count", done_count_out, 2);
        @(negedge clk_in);
        chk("abort_pulse_single", aborted_out, 0);

        // Abort on the completion edge of a 3-cycle job
        start_job(3);
        repeat (2) @(negedge clk_in);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("abort_last_pulse", aborted_out, 1);
        chk("abort_last_no_done", done_out, 0);
        chk("abort_last_count", done_count_out, 2);
        @(negedge clk_in);
        chk("abort_last_no_late_done", done_out, 0);

        // Abort while idle is ignored
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("idle_abort_ignored", aborted_out, 0);

        // Full 8-cycle job; remaining counts down when enabled
        start_job(8);
`ifdef JOB_STUB_REMAINING_EN
        for (int i = 0; i < 8; i++) begin
            chk("remaining_seq", remaining_out, 8 - i);
            @(negedge clk_in);
        end
        chk("remaining_done", remaining_out, 0);
`else
        repeat (8) @(negedge clk_in);
`endif
        chk("len8_done", done_out, 1);
        chk("len8_count", done_count_out, 3);

        // Reset in busy cycle 4 of an 8-cycle job
        start_job(8);
        repeat (3) @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        chk("rst_busy", busy_out, 0);
        chk("rst_on", on_out, 0);
        chk("rst_count", done_count_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_aborted", aborted_out, 0);
        @(negedge clk_in);
        chk("rst_no_late_pulse", done_out | aborted_out, 0);

        // Back-to-back: 300 jobs of length 2 with start held high
        start_in = 1'b1;
        delay_in = CW'(2);
        jobs = 0; dones = 0; busy_cyc = 0; cyc = 0; prev = 1'b0;
        while (dones < 300 && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
            if (busy_out && !prev) begin
                jobs++;
                if (jobs == 300) start_in = 1'b0;
            end
            if (busy_out) busy_cyc++;
            if (done_out) dones++;
            prev = busy_out;
        end
        chk("b2b_jobs", jobs, 300);
        chk("b2b_dones", dones, 300);
        chk("b2b_total_cycles", cyc, 900);
        chk("b2b_busy_cycles", busy_cyc, 600);
        chk("b2b_count_wrap", done_count_out, 44);
        @(negedge clk_in);
        chk("b2b_idle_after", busy_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
